// File: rtl/alarm_ctrl_pkg.sv
// Shared definitions for the alarm controller: FSM encoding and time field widths.
// The time-setting and display blocks reuse the same field widths.
package alarm_pkg;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;
    localparam int CNT_W  = 9;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2
    } state_t;

endpackage

// File: rtl/alarm_ctrl_if.sv
// Signal bundle between the clock/button front end (master) and alarm_ctrl (slave).
// There is no valid/ready pair here: tick_1hz, stop_btn and snooze_btn are single-cycle strobes, every other input is a level.
interface alarm_ctrl_if;
    import alarm_pkg::*;

    logic              tick_1hz;
    logic [HOUR_W-1:0] cur_hour;
    logic [MIN_W-1:0]  cur_min;
    logic [SEC_W-1:0]  cur_sec;
    logic [HOUR_W-1:0] alarm_hour;
    logic [MIN_W-1:0]  alarm_min;
    logic              armed;
    logic              stop_btn;
    logic              snooze_btn;
    logic              ring;
    logic              snoozing;
    logic [1:0]        snoozes_left;
    logic              missed;
    state_t            dbg_state;

    modport master (
        output tick_1hz, cur_hour, cur_min, cur_sec, alarm_hour, alarm_min,
               armed, stop_btn, snooze_btn,
        input  ring, snoozing, snoozes_left, missed, dbg_state
    );

    modport slave (
        input  tick_1hz, cur_hour, cur_min, cur_sec, alarm_hour, alarm_min,
               armed, stop_btn, snooze_btn,
        output ring, snoozing, snoozes_left, missed, dbg_state
    );

endinterface

// File: rtl/alarm_ctrl_sec_timer.sv
// Seconds counter shared by the ring-timeout and snooze intervals.
// done_o strobes in the cycle of the counted tick that reaches the terminal value.
module sec_timer
    import alarm_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear_i,
    input  logic         tick_i,
    input  logic [W-1:0] terminal_i,
    output logic         done_o
);

    logic [W-1:0] count_q, count_d, count_inc;

    assign count_inc = count_q + W'(1);
    // Compare against the post-increment value; the FSM leaves the state on done, so the count never wraps.
    assign done_o    = tick_i && (count_inc == terminal_i);

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (tick_i) begin
            count_d = count_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm sequencer: raises ring at the alarm time, handles stop, bounded snooze and ring timeout.
// All outputs are registered decodes of the next state.
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int RING_TIMEOUT_S = 60,
    parameter int SNOOZE_S       = 300,
    parameter int MAX_SNOOZES    = 3
) (
    input  logic         clk,
    input  logic         rst,
    alarm_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] RING_TERM   = CNT_W'(RING_TIMEOUT_S);
    localparam logic [CNT_W-1:0] SNOOZE_TERM = CNT_W'(SNOOZE_S);
    localparam logic [1:0]       SNOOZE_LOAD = 2'(MAX_SNOOZES);

    state_t           state_q, state_d;
    logic             fired_q, fired_d;
    logic [1:0]       left_q, left_d;
    logic             ring_q, ring_d;
    logic             snoozing_q, snoozing_d;
    logic             missed_q, missed_d;

    logic             hm_match, match;
    logic             stop_act, snooze_act, count_en;
    logic             cnt_clear, cnt_done, timeout;
    logic [CNT_W-1:0] cnt_term;

    assign hm_match = (bus.cur_hour == bus.alarm_hour) && (bus.cur_min == bus.alarm_min);
    assign match    = hm_match && (bus.cur_sec == '0);

    // A button that takes effect swallows a coincident tick; an ignored snooze does not.
    assign stop_act   = bus.armed && bus.stop_btn && (state_q != IDLE);
    assign snooze_act = bus.armed && bus.snooze_btn && !bus.stop_btn
                        && (state_q == RINGING) && (left_q != 2'd0);
    assign count_en   = bus.tick_1hz && bus.armed && (state_q != IDLE)
                        && !stop_act && !snooze_act;
    assign cnt_term   = (state_q == SNOOZE) ? SNOOZE_TERM : RING_TERM;

    sec_timer #(.W(CNT_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (cnt_clear),
        .tick_i     (count_en),
        .terminal_i (cnt_term),
        .done_o     (cnt_done)
    );

    always_comb begin
        state_d = state_q;
        timeout = 1'b0;
        if (!bus.armed) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (match && !fired_q) state_d = RINGING;
                end
                RINGING: begin
                    if (stop_act) begin
                        state_d = IDLE;
                    end else if (snooze_act) begin
                        state_d = SNOOZE;
                    end else if (cnt_done) begin
                        state_d = IDLE;
                        timeout = 1'b1;
                    end
                end
                SNOOZE: begin
                    if (stop_act) begin
                        state_d = IDLE;
                    end else if (cnt_done) begin
                        state_d = RINGING;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        ring_d     = (state_d == RINGING);
        snoozing_d = (state_d == SNOOZE);
        missed_d   = timeout;
        cnt_clear  = (state_d != state_q) || (state_q == IDLE);

        fired_d = fired_q;
        if ((state_d == RINGING) && (state_q != RINGING)) begin
            fired_d = 1'b1;
        end else if (!hm_match) begin
            fired_d = 1'b0;
        end

        // Remainder is held through IDLE so the last event's count stays visible.
        left_d = left_q;
        if ((state_q == IDLE) && (state_d == RINGING)) begin
            left_d = SNOOZE_LOAD;
        end else if (snooze_act) begin
            left_d = left_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            fired_q    <= 1'b0;
            left_q     <= 2'd0;
            ring_q     <= 1'b0;
            snoozing_q <= 1'b0;
            missed_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            fired_q    <= fired_d;
            left_q     <= left_d;
            ring_q     <= ring_d;
            snoozing_q <= snoozing_d;
            missed_q   <= missed_d;
        end
    end

    assign bus.ring         = ring_q;
    assign bus.snoozing     = snoozing_q;
    assign bus.snoozes_left = left_q;
    assign bus.missed       = missed_q;
    assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Self-checking bench for alarm_ctrl: directed scenarios plus a randomized run against a rule-level model.
module tb_alarm_ctrl;
  import alarm_pkg::*;

  localparam int RT = 5;
  localparam int SN = 4;
  localparam int MS = 3;
  localparam int M_IDLE = 0;
  localparam int M_RING = 1;
  localparam int M_SNZ  = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alarm_ctrl_if bus();

  alarm_ctrl #(.RING_TIMEOUT_S(RT), .SNOOZE_S(SN), .MAX_SNOOZES(MS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- model / scoreboard state ----------------
  int m_mode, m_elapsed, m_left;
  bit m_fired, m_missed;
  int tod;
  int n_vec = 0;
  int n_err = 0;
  bit sb_on = 0;
  logic [6:0] exp_q[$];

  function automatic logic [6:0] exp_pack();
    return {m_mode == M_RING, m_mode == M_SNZ, 2'(m_left), m_missed, 2'(m_mode)};
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_elapsed = 0; m_left = 0; m_fired = 0; m_missed = 0;
  endtask

  // One clock of the alarm rules, applied to the inputs currently driven.
  task automatic model_step();
    bit hm, mt, enter;
    hm = (bus.cur_hour == bus.alarm_hour) && (bus.cur_min == bus.alarm_min);
    mt = hm && (bus.cur_sec == 0);
    enter = 0;
    m_missed = 0;
    if (!bus.armed) begin
      m_mode = M_IDLE;
    end else if (m_mode == M_IDLE) begin
      if (mt && !m_fired) begin
        m_mode = M_RING; m_elapsed = 0; m_left = MS; enter = 1;
      end
    end else if (m_mode == M_RING) begin
      if (bus.stop_btn) m_mode = M_IDLE;
      else if (bus.snooze_btn && m_left > 0) begin
        m_left--; m_mode = M_SNZ; m_elapsed = 0;
      end else if (bus.tick_1hz) begin
        m_elapsed++;
        if (m_elapsed == RT) begin m_mode = M_IDLE; m_missed = 1; end
      end
    end else begin
      if (bus.stop_btn) m_mode = M_IDLE;
      else if (bus.tick_1hz) begin
        m_elapsed++;
        if (m_elapsed == SN) begin m_mode = M_RING; m_elapsed = 0; enter = 1; end
      end
    end
    if (enter) m_fired = 1;
    else if (!hm) m_fired = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply_tod();
    bus.cur_hour = 5'(tod / 3600);
    bus.cur_min  = 6'((tod / 60) % 60);
    bus.cur_sec  = 6'(tod % 60);
  endtask

  task automatic cycle();
    if (rst) model_reset();
    else model_step();
    if (sb_on) exp_q.push_back(exp_pack());
    @(posedge clk);
    #1;
    bus.tick_1hz = 1'b0;
    bus.stop_btn = 1'b0;
    bus.snooze_btn = 1'b0;
  endtask

  task automatic set_time(input int h, input int m, input int s);
    tod = h * 3600 + m * 60 + s;
    apply_tod();
    cycle();
  endtask

  // Tick cycle only; outputs are sampled right after the edge that follows it.
  task automatic tick_now();
    tod = (tod + 1) % 86400;
    apply_tod();
    bus.tick_1hz = 1'b1;
    cycle();
  endtask

  task automatic tick_sec();
    tick_now();
    cycle();
  endtask

  task automatic arm_trigger();
    set_time(7, 29, 59);
    tick_sec();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    cycle();
    cycle();
    n_vec++; if (bus.ring !== 1'b0) begin n_err++; $display("FAIL reset_ring: got %0b want 0", bus.ring); end
    n_vec++; if (bus.snoozing !== 1'b0) begin n_err++; $display("FAIL reset_snoozing: got %0b want 0", bus.snoozing); end
    n_vec++; if (bus.snoozes_left !== 2'd0) begin n_err++; $display("FAIL reset_left: got %0d want 0", bus.snoozes_left); end
    n_vec++; if (bus.missed !== 1'b0) begin n_err++; $display("FAIL reset_missed: got %0b want 0", bus.missed); end
    n_vec++; if (bus.dbg_state !== IDLE) begin n_err++; $display("FAIL reset_state: got %0d want 0", bus.dbg_state); end
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_trigger();
    set_time(7, 29, 58);
    tick_sec();
    n_vec++; if (bus.ring !== 1'b0) begin n_err++; $display("FAIL trig_early: ring got %0b want 0", bus.ring); end
    tick_now();
    n_vec++; if (bus.ring !== 1'b1) begin n_err++; $display("FAIL trig_ring: got %0b want 1", bus.ring); end
    n_vec++; if (bus.snoozes_left !== 2'd3) begin n_err++; $display("FAIL trig_left: got %0d want 3", bus.snoozes_left); end
    cycle();
  endtask

  task automatic test_stop_no_retrigger();
    int hits;
    // Stop at :03 because the 5 s timeout would end the ring before :10.
    repeat (3) tick_sec();
    bus.stop_btn = 1'b1;
    cycle();
    n_vec++; if (bus.ring !== 1'b0) begin n_err++; $display("FAIL stop_ring: got %0b want 0", bus.ring); end
    n_vec++; if (bus.snoozes_left !== 2'd3) begin n_err++; $display("FAIL stop_left: got %0d want 3", bus.snoozes_left); end
    hits = 0;
    while (tod % 60 != 59) begin
      tick_sec();
      if (bus.ring) hits++;
    end
    n_vec++; if (hits !== 0) begin n_err++; $display("FAIL stop_retrig: ring cycles %0d want 0", hits); end
    set_time(7, 31, 0);
    arm_trigger();
    n_vec++; if (bus.ring !== 1'b1) begin n_err++; $display("FAIL next_day_ring: got %0b want 1", bus.ring); end
  endtask

  task automatic test_timeout();
    repeat (RT - 1) tick_sec();
    n_vec++; if (bus.ring !== 1'b1) begin n_err++; $display("FAIL tmo_early: ring got %0b want 1", bus.ring); end
    tick_now();
    n_vec++; if (bus.ring !== 1'b0) begin n_err++; $display("FAIL tmo_ring: got %0b want 0", bus.ring); end
    n_vec++; if (bus.missed !== 1'b1) begin n_err++; $display("FAIL tmo_missed: got %0b want 1", bus.missed); end
    n_vec++; if (bus.dbg_state !== IDLE) begin n_err++; $display("FAIL tmo_state: got %0d want 0", bus.dbg_state); end
    cycle();
    n_vec++; if (bus.missed !== 1'b0) begin n_err++; $display("FAIL tmo_pulse: missed got %0b want 0", bus.missed); end
  endtask

  task automatic test_snooze();
    arm_trigger();
    for (int r = 0; r < 3; r++) begin
      bus.snooze_btn = 1'b1;
      cycle();
      n_vec++; if (bus.snoozing !== 1'b1 || bus.ring !== 1'b0) begin
        n_err++; $display("FAIL snz_enter: snoozing/ring got %0b/%0b want 1/0", bus.snoozing, bus.ring); end
      n_vec++; if (bus.snoozes_left !== 2'(2 - r)) begin
        n_err++; $display("FAIL snz_left: got %0d want %0d", bus.snoozes_left, 2 - r); end
      repeat (SN - 1) tick_sec();
      n_vec++; if (bus.snoozing !== 1'b1) begin n_err++; $display("FAIL snz_hold: got %0b want 1", bus.snoozing); end
      tick_now();
      n_vec++; if (bus.ring !== 1'b1 || bus.snoozing !== 1'b0) begin
        n_err++; $display("FAIL snz_expire: ring/snoozing got %0b/%0b want 1/0", bus.ring, bus.snoozing); end
      cycle();
    end
    bus.snooze_btn = 1'b1;
    cycle();
    n_vec++; if (bus.ring !== 1'b1 || bus.snoozing !== 1'b0 || bus.snoozes_left !== 2'd0) begin
      n_err++; $display("FAIL snz_exhausted: ring/snoozing/left got %0b/%0b/%0d want 1/0/0",
                        bus.ring, bus.snoozing, bus.snoozes_left); end
    bus.stop_btn = 1'b1;
    cycle();
  endtask

  task automatic test_simultaneous();
    arm_trigger();
    tod = (tod + 1) % 86400;
    apply_tod();
    bus.stop_btn = 1'b1; bus.snooze_btn = 1'b1; bus.tick_1hz = 1'b1;
    cycle();
    n_vec++; if (bus.ring !== 1'b0 || bus.snoozing !== 1'b0 || bus.dbg_state !== IDLE) begin
      n_err++; $display("FAIL sim_stop: ring/snoozing/state got %0b/%0b/%0d want 0/0/0",
                        bus.ring, bus.snoozing, bus.dbg_state); end
    n_vec++; if (bus.snoozes_left !== 2'd3) begin n_err++; $display("FAIL sim_left: got %0d want 3", bus.snoozes_left); end
    arm_trigger();
    bus.snooze_btn = 1'b1;
    cycle();
    bus.armed = 1'b0;
    cycle();
    n_vec++; if (bus.snoozing !== 1'b0 || bus.ring !== 1'b0 || bus.dbg_state !== IDLE) begin
      n_err++; $display("FAIL disarm: snoozing/ring/state got %0b/%0b/%0d want 0/0/0",
                        bus.snoozing, bus.ring, bus.dbg_state); end
    n_vec++; if (bus.snoozes_left !== 2'd2) begin n_err++; $display("FAIL disarm_left: got %0d want 2", bus.snoozes_left); end
    bus.armed = 1'b1;
    cycle();
  endtask

  task automatic test_reset_mid_ring();
    int hits;
    arm_trigger();
    repeat (3) tick_sec();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    n_vec++; if ({bus.ring, bus.snoozing, bus.snoozes_left, bus.missed} !== 5'b0) begin
      n_err++; $display("FAIL rst_mid: ring/snoozing/left/missed got %0b/%0b/%0d/%0b want 0/0/0/0",
                        bus.ring, bus.snoozing, bus.snoozes_left, bus.missed); end
    hits = 0;
    while (tod % 60 != 59) begin
      tick_sec();
      if (bus.ring) hits++;
    end
    n_vec++; if (hits !== 0) begin n_err++; $display("FAIL rst_retrig: ring cycles %0d want 0", hits); end
  endtask

  task automatic test_random();
    logic [6:0] exp_v, act_v;
    sb_on = 1;
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      bus.armed = ($urandom_range(0, 59) != 0);
      bus.stop_btn = ($urandom_range(0, 99) == 0);
      bus.snooze_btn = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 49) == 0) tod = 7 * 3600 + 29 * 60 + 50 + $urandom_range(0, 80);
      if ($urandom_range(0, 199) == 0) bus.alarm_min = 6'($urandom_range(29, 31));
      if ($urandom_range(0, 3) == 0) begin
        bus.tick_1hz = 1'b1;
        tod = (tod + 1) % 86400;
      end
      apply_tod();
      cycle();
      exp_v = exp_q.pop_front();
      act_v = {bus.ring, bus.snoozing, bus.snoozes_left, bus.missed, 2'(bus.dbg_state)};
      n_vec++;
      if (act_v !== exp_v) begin
        n_err++;
        $display("FAIL rand[%0d]: {ring,snz,left,missed,state} got %b want %b", i, act_v, exp_v);
      end
    end
    sb_on = 0;
    rst = 1'b0;
    bus.armed = 1'b1;
    bus.alarm_min = 6'd30;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    bus.tick_1hz = 1'b0;
    bus.stop_btn = 1'b0;
    bus.snooze_btn = 1'b0;
    bus.armed = 1'b1;
    bus.alarm_hour = 5'd7;
    bus.alarm_min = 6'd30;
    tod = 7 * 3600;
    apply_tod();
    model_reset();

    test_reset();
    test_trigger();
    test_stop_no_retrigger();
    test_timeout();
    test_snooze();
    test_simultaneous();
    test_reset_mid_ring();
    test_random();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
